layered_color_mapper: RTL and testbench

- Parametrised successor to the single-sprite palette colour mapper.
- Composites NUM_LAYERS sprite layers over a background index using fixed priority (layer 0 on top) and a transparent index.
- Looks up a run-time writable palette, then applies a global fade and a per-frame flash effect on layer 0 (for example, a damaged player).
- Sits between the sprite/background ROM readers and the VGA controller, with a fixed 2-cycle latency and delayed pixel coordinates.

---
 rtl/color_pkg.sv | 33 +++
 rtl/palette_ram.sv | 39 +++
 rtl/layered_color_mapper.sv | 146 ++++++++++++++
 tb/tb_layered_color_mapper.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared colour types, the power-on palette and the fade helper for the
// layered colour mapper.
package color_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned DEFAULT_DEPTH = 16;

  localparam rgb_t DEFAULT_PALETTE [DEFAULT_DEPTH] = '{
    24'hFF00FF, 24'h2D2D0C, 24'h282807, 24'h202000,
    24'h000000, 24'h570C0C, 24'hD21212, 24'hFF0000,
    24'hFFD400, 24'hFF9800, 24'hFF3300, 24'hF73C04,
    24'hCE0000, 24'h8F5600, 24'h4F2F00, 24'h6F5B00
  };

  // Reset value for palette slot i; slots beyond the default table are black.
  function automatic logic [23:0] default_entry(input int unsigned i);
    logic [3:0] k;
    k = i[3:0];
    if (i < DEFAULT_DEPTH) return DEFAULT_PALETTE[k];
    return '0;
  endfunction

  // Logical right shift of one channel; channels up to 32 bits wide.
  function automatic logic [31:0] fade_ch(input logic [31:0] c, input logic [2:0] s);
    return c >> s;
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Register-array palette: reset-initialised, one write port, one
// asynchronous read port with write-first bypass.
import color_pkg::*;

module palette_ram #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage: reset loads the default table and wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(default_entry(i));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: a same-cycle write to the read address is forwarded.
  always_comb begin
    rdata = mem[raddr];
    if (we && (waddr == raddr)) rdata = wdata;
  end

endmodule

// File: rtl/layered_color_mapper.sv
// Composites NUM_LAYERS sprite layers over a background index, looks up a
// writable palette, applies layer-0 flash and global fade. Fixed 2-cycle
// latency with coordinates and valid carried alongside.
import color_pkg::*;

module layered_color_mapper #(
  parameter int unsigned             NUM_LAYERS      = 4,
  parameter int unsigned             IDX_W           = 4,
  parameter int unsigned             COLOR_W         = 8,
  parameter logic [IDX_W-1:0]        TRANSPARENT_IDX = '0,
  parameter int unsigned             FLASH_FRAMES    = 4,
  parameter logic [3*COLOR_W-1:0]    FLASH_COLOR     = 24'hFFFFFF
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        pix_valid,
  input  logic                        frame_start,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic [NUM_LAYERS-1:0]       layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [IDX_W-1:0]            bg_idx,
  input  logic                        pal_we,
  input  logic [IDX_W-1:0]            pal_waddr,
  input  logic [3*COLOR_W-1:0]        pal_wdata,
  input  logic [2:0]                  fade_shift,
  input  logic                        flash_en,
  output logic                        out_valid,
  output logic [9:0]                  out_x,
  output logic [9:0]                  out_y,
  output logic [COLOR_W-1:0]          VGA_R,
  output logic [COLOR_W-1:0]          VGA_G,
  output logic [COLOR_W-1:0]          VGA_B
);

  localparam int unsigned CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int unsigned PAL_W = 3 * COLOR_W;

  logic               found;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_l0;

  logic               s1_valid;
  logic [9:0]         s1_x;
  logic [9:0]         s1_y;
  logic [IDX_W-1:0]   s1_idx;
  logic               s1_l0;

  logic [CNT_W-1:0]   flash_cnt;
  logic               flash_phase;

  logic [PAL_W-1:0]   pal_rdata;
  logic [PAL_W-1:0]   rgb;
  logic [COLOR_W-1:0] ch_r;
  logic [COLOR_W-1:0] ch_g;
  logic [COLOR_W-1:0] ch_b;

  palette_ram #(
    .IDX_W  (IDX_W),
    .DATA_W (PAL_W)
  ) u_palette (
    .clk     (Clk),
    .reset_n (Reset_n),
    .we      (pal_we),
    .waddr   (pal_waddr),
    .wdata   (pal_wdata),
    .raddr   (s1_idx),
    .rdata   (pal_rdata)
  );

  // Priority select: first opaque hit from layer 0 upward, else background.
  always_comb begin
    found   = 1'b0;
    sel_idx = bg_idx;
    sel_l0  = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!found && layer_hit[i] &&
          (layer_idx[i*IDX_W +: IDX_W] != TRANSPARENT_IDX)) begin
        found   = 1'b1;
        sel_idx = layer_idx[i*IDX_W +: IDX_W];
        sel_l0  = (i == 0);
      end
    end
  end

  // Stage 1 register: winning index plus pixel attributes.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_idx   <= '0;
      s1_l0    <= 1'b0;
    end else begin
      s1_valid <= pix_valid;
      s1_x     <= DrawX;
      s1_y     <= DrawY;
      s1_idx   <= sel_idx;
      s1_l0    <= sel_l0;
    end
  end

  // Flash timing: counts frames while enabled; disable clears immediately.
  always_ff @(posedge Clk) begin
    if (!Reset_n || !flash_en) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame_start) begin
      if (flash_cnt == CNT_W'(FLASH_FRAMES - 1)) begin
        flash_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        flash_cnt <= flash_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 2 colour: palette or flash override, then per-channel fade.
  always_comb begin
    rgb = pal_rdata;
    if (s1_l0 && flash_en && flash_phase) rgb = FLASH_COLOR;
    ch_r = COLOR_W'(fade_ch(32'(rgb[3*COLOR_W-1 -: COLOR_W]), fade_shift));
    ch_g = COLOR_W'(fade_ch(32'(rgb[2*COLOR_W-1 -: COLOR_W]), fade_shift));
    ch_b = COLOR_W'(fade_ch(32'(rgb[COLOR_W-1 -: COLOR_W]), fade_shift));
  end

  // Stage 2 register: outputs, with RGB blanked outside the active region.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else begin
      out_valid <= s1_valid;
      out_x     <= s1_x;
      out_y     <= s1_y;
      VGA_R     <= s1_valid ? ch_r : '0;
      VGA_G     <= s1_valid ? ch_g : '0;
      VGA_B     <= s1_valid ? ch_b : '0;
    end
  end

endmodule

// File: tb/tb_layered_color_mapper.sv
// Bench for layered_color_mapper: directed scenarios with fixed expected
// colours, then random traffic against a cycle-level reference model.
module tb_layered_color_mapper;

  localparam int NL = 4;
  localparam int FF = 2;

  logic        Clk;
  logic        Reset_n;
  logic        pix_valid;
  logic        frame_start;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [3:0]  layer_hit;
  logic [15:0] layer_idx;
  logic [3:0]  bg_idx;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [23:0] pal_wdata;
  logic [2:0]  fade_shift;
  logic        flash_en;
  logic        out_valid;
  logic [9:0]  out_x;
  logic [9:0]  out_y;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;

  layered_color_mapper #(.FLASH_FRAMES(FF)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .layer_hit   (layer_hit),
    .layer_idx   (layer_idx),
    .bg_idx      (bg_idx),
    .pal_we      (pal_we),
    .pal_waddr   (pal_waddr),
    .pal_wdata   (pal_wdata),
    .fade_shift  (fade_shift),
    .flash_en    (flash_en),
    .out_valid   (out_valid),
    .out_x       (out_x),
    .out_y       (out_y),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int total = 0;
  int bad   = 0;

  logic [23:0] def_tab [16] = '{
    24'hFF00FF, 24'h2D2D0C, 24'h282807, 24'h202000,
    24'h000000, 24'h570C0C, 24'hD21212, 24'hFF0000,
    24'hFFD400, 24'hFF9800, 24'hFF3300, 24'hF73C04,
    24'hCE0000, 24'h8F5600, 24'h4F2F00, 24'h6F5B00
  };

  // Reference state: palette contents, frame pulses since enable, and the
  // pixel that will be coloured on the next clock.
  logic [23:0] m_pal [16];
  int          m_pulses;
  logic        p_valid;
  logic [9:0]  p_x;
  logic [9:0]  p_y;
  logic [3:0]  p_idx;
  logic        p_l0;
  logic [44:0] exp_out;

  task automatic model_step();
    logic [23:0] c;
    logic [7:0]  r, g, b;
    bit          phase;
    if (!Reset_n) begin
      exp_out = '0;
      p_valid = 1'b0; p_x = '0; p_y = '0; p_idx = '0; p_l0 = 1'b0;
      for (int i = 0; i < 16; i++) m_pal[i] = def_tab[i];
      m_pulses = 0;
      return;
    end
    phase = ((m_pulses / FF) % 2) == 1;
    c = (pal_we && pal_waddr == p_idx) ? pal_wdata : m_pal[p_idx];
    if (p_l0 && flash_en && phase) c = 24'hFFFFFF;
    r = c[23:16] >> fade_shift;
    g = c[15:8]  >> fade_shift;
    b = c[7:0]   >> fade_shift;
    if (!p_valid) begin r = '0; g = '0; b = '0; end
    exp_out = {p_valid, p_x, p_y, r, g, b};
    if (pal_we) m_pal[pal_waddr] = pal_wdata;
    if (!flash_en) m_pulses = 0;
    else if (frame_start) m_pulses++;
    p_valid = pix_valid; p_x = DrawX; p_y = DrawY;
    p_idx = bg_idx; p_l0 = 1'b0;
    for (int i = NL - 1; i >= 0; i--) begin
      if (layer_hit[i] && layer_idx[i*4 +: 4] != 4'd0) begin
        p_idx = layer_idx[i*4 +: 4];
        p_l0  = (i == 0);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    total++;
    assert ({out_valid, out_x, out_y, VGA_R, VGA_G, VGA_B} === exp_out) else begin
      bad++;
      $error("FAIL model t=%0t obs=%h exp=%h", $time,
             {out_valid, out_x, out_y, VGA_R, VGA_G, VGA_B}, exp_out);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  initial begin
    Reset_n = 1'b0; pix_valid = 1'b0; frame_start = 1'b0;
    DrawX = '0; DrawY = '0; layer_hit = '0; layer_idx = '0; bg_idx = '0;
    pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0; fade_shift = '0; flash_en = 1'b0;

    // Reset held for three cycles: everything zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_out", 64'({out_valid, out_x, out_y, VGA_R, VGA_G, VGA_B}), 64'd0);
    end

    // Background only after reset.
    Reset_n = 1'b1; pix_valid = 1'b1; bg_idx = 4'd6; DrawX = 10'd10; DrawY = 10'd20;
    tick(); tick();
    chk("bg_rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'h D21212);
    chk("bg_valid_xy", 64'({out_valid, out_x, out_y}), 64'({1'b1, 10'd10, 10'd20}));

    // Priority: transparent layer 0 lets layer 1 through; opaque layer 0 wins.
    layer_hit = 4'b0011; layer_idx = {4'd0, 4'd0, 4'd8, 4'd0}; bg_idx = 4'd1;
    tick();
    layer_idx = {4'd0, 4'd0, 4'd8, 4'd7};
    tick();
    chk("prio_transp", 64'({VGA_R, VGA_G, VGA_B}), 64'h FFD400);
    tick();
    chk("prio_l0", 64'({VGA_R, VGA_G, VGA_B}), 64'h FF0000);

    // Palette write coinciding with a stage-2 lookup of the same index.
    layer_hit = '0; bg_idx = 4'd5;
    tick();
    pal_we = 1'b1; pal_waddr = 4'd5; pal_wdata = 24'h123456;
    tick();
    chk("pal_bypass", 64'({VGA_R, VGA_G, VGA_B}), 64'h 123456);
    pal_we = 1'b0;
    tick();
    chk("pal_after1", 64'({VGA_R, VGA_G, VGA_B}), 64'h 123456);
    tick();
    chk("pal_after2", 64'({VGA_R, VGA_G, VGA_B}), 64'h 123456);

    // Fade: shift change applies to the pixel already in flight.
    bg_idx = 4'd8; fade_shift = 3'd1;
    tick(); tick();
    chk("fade1", 64'({VGA_R, VGA_G, VGA_B}), 64'h 7F6A00);
    fade_shift = 3'd3;
    tick();
    chk("fade3", 64'({VGA_R, VGA_G, VGA_B}), 64'h 1F1A00);
    fade_shift = 3'd7;
    tick();
    chk("fade7", 64'({VGA_R, VGA_G, VGA_B}), 64'h 010100);
    fade_shift = 3'd0;

    // Flash with two frames per half-period.
    flash_en = 1'b1; layer_hit = 4'b0001; layer_idx = {4'd0, 4'd0, 4'd0, 4'd9};
    for (int f = 0; f < 6; f++) begin
      repeat (3) tick();
      chk($sformatf("flash_f%0d", f), 64'({VGA_R, VGA_G, VGA_B}),
          ((f / 2) % 2 == 1) ? 64'h FFFFFF : 64'h FF9800);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
    repeat (2) tick();
    chk("flash_f6_on", 64'({VGA_R, VGA_G, VGA_B}), 64'h FFFFFF);
    flash_en = 1'b0;
    tick();
    chk("flash_off", 64'({VGA_R, VGA_G, VGA_B}), 64'h FF9800);

    // Blanking still carries coordinates.
    pix_valid = 1'b0; DrawX = 10'd639; DrawY = 10'd479;
    tick(); tick();
    chk("blank", 64'({out_valid, out_x, out_y, VGA_R, VGA_G, VGA_B}),
        64'({1'b0, 10'd639, 10'd479, 24'h000000}));

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      Reset_n     = ($urandom_range(0, 63) != 0);
      pix_valid   = 1'($urandom_range(0, 1));
      frame_start = ($urandom_range(0, 7) == 0);
      flash_en    = ($urandom_range(0, 7) != 0);
      DrawX       = 10'($urandom_range(0, 1023));
      DrawY       = 10'($urandom_range(0, 1023));
      layer_hit   = 4'($urandom_range(0, 15));
      for (int l = 0; l < NL; l++)
        layer_idx[l*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bg_idx      = 4'($urandom_range(0, 15));
      pal_we      = ($urandom_range(0, 7) == 0);
      pal_waddr   = 4'($urandom_range(0, 15));
      pal_wdata   = 24'($urandom());
      fade_shift  = 3'($urandom_range(0, 7));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
